frv_lsu_split: RTL and testbench
================================

Name: frv_lsu_split

Overview:
- Load/store unit with a split request/response data bus and load-data return path.
- Stores are posted: they retire at grant. Loads retire when their response arrives.
- An in-order tracker of depth MAX_OUTSTANDING matches responses to requests.
- Sits between the core's execute/memory stage and the data-memory port. Also keeps the single-cycle MMIO side channel.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- MAX_OUTSTANDING, 2, tracker depth (≥1). Number of granted, un-responded requests.
- MMIO_BASE_ADDR, 32'h0000_1000, MMIO region base.
- MMIO_BASE_MASK, 32'hFFFF_F000, MMIO region mask.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  reset, synchronous active-low.
- lsu_valid  in  1  instruction present.
- lsu_addr / lsu_wdata  in  XLEN  address / store data.
- lsu_load, lsu_store, lsu_byte, lsu_half, lsu_word, lsu_signed  in  1 each  op decode.
- pipe_prog  in  1  pipeline advances; also kills the current instruction.
- hold_lsu_req  in  1  suppress new requests.
- lsu_ready  out  1  instruction complete.
- lsu_a_error  out  1  misaligned address.
- lsu_mmio  out  1  access targets MMIO.
- lsu_rdata  out  XLEN  formatted load data; valid with lsu_ready on loads.
- lsu_bus_error  out  1  error response for the current load.
- lsu_store_berr  out  1  one-cycle pulse: error response to a posted store (imprecise).
- mmio_en, mmio_wen  out  1  MMIO strobe / write.
- mmio_addr, mmio_wdata  out  32  MMIO address / write data.
- mmio_rdata  in  32  MMIO read data, same cycle.
- dmem_req  out  1  request.
- dmem_wen  out  1  write enable.
- dmem_strb  out  4  byte strobes.
- dmem_addr, dmem_wdata  out  XLEN  word-aligned address / lane-aligned data.
- dmem_gnt  in  1  request accepted.
- dmem_recv  in  1  response valid; always accepted.
- dmem_rdata  in  XLEN  response data.
- dmem_error  in  1  response error.

Behaviour:
Reset (g_resetn=0 at posedge):
- state=S_REQ; tracker empty.
- Held rdata=0, held error=0, lsu_store_berr=0.
- With lsu_valid=0, all request/ready outputs are 0.

Combinational request side:
- lsu_a_error = half&addr[0] | word&|addr[1:0].
- lsu_mmio = valid & (addr&MASK)==BASE.
- dmem_addr = addr&~3.
- dmem_wdata and dmem_strb are lane-replicated per byte/half/word offset.

FSM:
- S_REQ
  - a_error: lsu_ready=1, no request.
  - MMIO: mmio_en=valid&mmio&!hold&tracker_empty. lsu_ready=mmio_en. lsu_rdata formatted from mmio_rdata.
  - Memory: dmem_req=valid&!a_error&!mmio&!hold&!full. Full uses the registered count; no same-cycle pop bypass.
  - On req&gnt: push {load, byte, half, signed, addr[1:0], discard=0}.
  - Store on grant: lsu_ready=1 that cycle.
  - Load on grant: go to S_RSP.
  - Completion with !pipe_prog: go to S_DONE, capturing rdata/error.
  - Completion with pipe_prog: stay in S_REQ.
- S_RSP
  - dmem_req=0.
  - The load completes when dmem_recv pops the entry it pushed. Responses are strictly in order; intervening pops are older stores.
  - On that pop: lsu_ready=1; lsu_rdata = format(dmem_rdata); lsu_bus_error=dmem_error.
  - Then: pipe_prog → S_REQ; else → S_DONE with captured values.
  - pipe_prog before the response (kill): set discard on that entry; go to S_REQ. Its response is later popped silently.
- S_DONE
  - lsu_ready=1; lsu_rdata and lsu_bus_error from registers.
  - pipe_prog → S_REQ.

Format:
- Lane selected by addr[1:0] for bytes, addr[1] for halves.
- Zero- or sign-extend from bit 7/15 per lsu_signed; words pass through.

Tracker:
- Push (gnt) and pop (recv) in the same cycle are legal at any occupancy; count unchanged.
- dmem_recv with empty tracker is a protocol violation; assertion only, state unchanged.
- Store-entry pop with dmem_error: lsu_store_berr=1 the next cycle for exactly one cycle.
- Discarded entries never raise lsu_bus_error or lsu_store_berr.

Decomposition:
- In frv_common.vh: FSM encodings S_REQ/S_RSP/S_DONE and tracker entry field offsets/width (7 bits).
- Sub-module frv_lsu_tracker: parametrised FIFO with push, pop, full, empty, head entry, set_discard_newest.
- Load formatting is a local function.

Test Plan:
- Aligned word load 0x2000: gnt cycle 1, recv cycle 4 with rdata 0xCAFEBABE → lsu_ready only cycle 4; lsu_rdata=0xCAFEBABE.
- Signed byte load 0x2003, rdata 0x80112233 → lsu_rdata=0xFFFFFF80. Unsigned half at 0x2002 → 0x00008011.
- Three back-to-back stores, MAX_OUTSTANDING=2, no recv → two grants; dmem_req low on the third. One recv → third issues next cycle.
- Store granted, then a load granted; recv store with error, then recv load → lsu_store_berr pulses one cycle; load completes on the second recv.
- Load issued, pipe_prog before recv → back to S_REQ; later response dropped with no lsu_ready, lsu_bus_error or lsu_store_berr.
- MMIO load 0x1004 with store outstanding → mmio_en held 0 until tracker empty, then mmio_en=1, lsu_ready=1 in the same cycle. Half at 0x2001 → lsu_a_error=1, lsu_ready=1, dmem_req=0.

Source files
------------

// File: rtl/frv_lsu_split_pkg.sv
// Shared definitions for the split-bus load/store unit: FSM encodings and
// the layout of one outstanding-request tracker entry.
package frv_lsu_split_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_RSP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One granted request awaiting its response. Bit order from MSB:
  // load, byte, half, signed, offset[1:0], discard.
  typedef struct packed {
    logic       load;
    logic       is_byte;
    logic       half;
    logic       sgn;
    logic [1:0] off;
    logic       discard;
  } trk_entry_t;

  localparam int TRK_ENTRY_W = $bits(trk_entry_t);

endpackage

// File: rtl/frv_lsu_split_tracker.sv
// In-order FIFO of granted, un-responded requests. Push and pop may happen
// in the same cycle at any occupancy; callers gate push by !full and pop by
// !empty. The newest entry can be marked discarded when its load is killed.
module frv_lsu_split_tracker
  import frv_lsu_split_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         g_clk,
  input  logic                         g_resetn,
  input  logic                         push_i,
  input  trk_entry_t                   push_entry_i,
  input  logic                         pop_i,
  input  logic                         set_discard_newest_i,
  output logic                         full_o,
  output logic                         empty_o,
  output trk_entry_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  trk_entry_t          mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q, newest;
  logic [CW-1:0]       count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign newest  = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - PW'(1);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every block sees
      // the pre-edge values regardless of evaluation order.
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; a kill only ever touches the youngest entry.
  always_ff @(posedge g_clk) begin
    // NOTE: storage is not reset; an entry is only read while count_q says
    // it is occupied, so its contents before the first push are irrelevant.
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    if (set_discard_newest_i) mem_q[newest].discard <= 1'b1;
  end

endmodule

// File: rtl/frv_lsu_split.sv
// Load/store unit for a split request/response data bus. Stores retire at
// grant, loads retire on their in-order response; a single-cycle MMIO side
// channel is served only when no memory request is outstanding.
module frv_lsu_split
  import frv_lsu_split_pkg::*;
#(
  parameter int          XLEN            = 32,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] MMIO_BASE_ADDR  = 32'h0000_1000,
  parameter logic [31:0] MMIO_BASE_MASK  = 32'hFFFF_F000
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            lsu_valid,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic            lsu_load,
  input  logic            lsu_store,
  input  logic            lsu_byte,
  input  logic            lsu_half,
  input  logic            lsu_word,
  input  logic            lsu_signed,
  input  logic            pipe_prog,
  input  logic            hold_lsu_req,
  output logic            lsu_ready,
  output logic            lsu_a_error,
  output logic            lsu_mmio,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_bus_error,
  output logic            lsu_store_berr,
  output logic            mmio_en,
  output logic            mmio_wen,
  output logic [31:0]     mmio_addr,
  output logic [31:0]     mmio_wdata,
  input  logic [31:0]     mmio_rdata,
  output logic            dmem_req,
  output logic            dmem_wen,
  output logic [3:0]      dmem_strb,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_recv,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_error
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] rdata_q;
  logic            berr_q, store_berr_q;
  logic            in_req, push, pop, rsp_pop, set_discard;
  logic            trk_full, trk_empty;
  logic [CW-1:0]   trk_count;
  trk_entry_t      trk_head, push_entry;

  // Select the addressed lane and zero/sign-extend it to XLEN.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] d,
                                               input logic b, input logic h,
                                               input logic s, input logic [1:0] off);
    logic [7:0]  bv;
    logic [15:0] hv;
    unique case (off)
      2'd0:    bv = d[7:0];
      2'd1:    bv = d[15:8];
      2'd2:    bv = d[23:16];
      default: bv = d[31:24];
    endcase
    hv = off[1] ? d[31:16] : d[15:0];
    if (b)      return {{24{s & bv[7]}}, bv};
    else if (h) return {{16{s & hv[15]}}, hv};
    else        return d;
  endfunction

  assign lsu_a_error = (lsu_half & lsu_addr[0]) | (lsu_word & |lsu_addr[1:0]);
  assign lsu_mmio    = lsu_valid & ((lsu_addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR);
  assign in_req      = (state_q == S_REQ);

  assign mmio_en    = in_req & lsu_valid & lsu_mmio & ~lsu_a_error & ~hold_lsu_req & trk_empty;
  assign mmio_wen   = mmio_en & lsu_store;
  assign mmio_addr  = lsu_addr;
  assign mmio_wdata = lsu_wdata;

  // Full is taken from the registered count: a same-cycle pop does not free
  // a slot for a new request until the following cycle.
  assign dmem_req  = in_req & lsu_valid & ~lsu_a_error & ~lsu_mmio & ~hold_lsu_req & ~trk_full;
  assign dmem_wen  = lsu_store;
  assign dmem_addr = {lsu_addr[XLEN-1:2], 2'b00};

  assign push    = dmem_req & dmem_gnt;
  assign pop     = dmem_recv & ~trk_empty;
  // No pushes happen while waiting, so the waiting load is the newest entry:
  // its response is the pop that finds it alone in the tracker.
  assign rsp_pop = (state_q == S_RSP) & pop & (trk_count == CW'(1));

  assign push_entry = '{load: lsu_load, is_byte: lsu_byte, half: lsu_half,
                        sgn: lsu_signed, off: lsu_addr[1:0], discard: 1'b0};

  assign lsu_store_berr = store_berr_q;

  // Replicate store data across lanes and strobe the addressed bytes.
  always_comb begin
    dmem_wdata = lsu_wdata;
    dmem_strb  = 4'b1111;
    if (lsu_byte) begin
      dmem_wdata = {4{lsu_wdata[7:0]}};
      dmem_strb  = 4'b0001 << lsu_addr[1:0];
    end else if (lsu_half) begin
      dmem_wdata = {2{lsu_wdata[15:0]}};
      dmem_strb  = lsu_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Completion, result selection and next state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d       = state_q;
    lsu_ready     = 1'b0;
    lsu_rdata     = '0;
    lsu_bus_error = 1'b0;
    set_discard   = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (lsu_valid & lsu_a_error) begin
          lsu_ready = 1'b1;
        end else if (mmio_en) begin
          lsu_ready = 1'b1;
          lsu_rdata = fmt_load(mmio_rdata, lsu_byte, lsu_half, lsu_signed, lsu_addr[1:0]);
        end else if (push & lsu_store) begin
          lsu_ready = 1'b1;
        end else if (push & lsu_load) begin
          state_d = S_RSP;
        end
        if (lsu_ready & ~pipe_prog) state_d = S_DONE;
      end
      S_RSP: begin
        if (rsp_pop) begin
          lsu_ready     = 1'b1;
          lsu_rdata     = fmt_load(dmem_rdata, trk_head.is_byte, trk_head.half,
                                   trk_head.sgn, trk_head.off);
          lsu_bus_error = dmem_error;
          state_d       = pipe_prog ? S_REQ : S_DONE;
        end else if (pipe_prog) begin
          set_discard = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_DONE: begin
        lsu_ready     = 1'b1;
        lsu_rdata     = rdata_q;
        lsu_bus_error = berr_q;
        if (pipe_prog) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // State, held result and the imprecise store-error pulse.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= S_REQ;
      rdata_q      <= '0;
      berr_q       <= 1'b0;
      store_berr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_berr_q <= pop & ~trk_head.load & ~trk_head.discard & dmem_error;
      if ((state_q != S_DONE) && (state_d == S_DONE)) begin
        rdata_q <= lsu_rdata;
        berr_q  <= lsu_bus_error;
      end
    end
  end

  frv_lsu_split_tracker #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .g_clk                (g_clk),
    .g_resetn             (g_resetn),
    .push_i               (push),
    .push_entry_i         (push_entry),
    .pop_i                (pop),
    .set_discard_newest_i (set_discard),
    .full_o               (trk_full),
    .empty_o              (trk_empty),
    .head_o               (trk_head),
    .count_o              (trk_count)
  );

  // A response with nothing outstanding breaks the bus protocol.
  assert property (@(posedge g_clk) disable iff (!g_resetn) dmem_recv |-> !trk_empty);

endmodule

// File: tb/tb_frv_lsu_split.sv
// Directed bench for frv_lsu_split: inputs change 1 ns after a rising edge,
// outputs are compared 4 ns later, mid-cycle.
module tb_frv_lsu_split;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        lsu_valid = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        lsu_load = 1'b0, lsu_store = 1'b0, lsu_byte = 1'b0;
  logic        lsu_half = 1'b0, lsu_word = 1'b0, lsu_signed = 1'b0;
  logic        pipe_prog = 1'b0, hold_lsu_req = 1'b0;
  logic        lsu_ready, lsu_a_error, lsu_mmio, lsu_bus_error, lsu_store_berr;
  logic [31:0] lsu_rdata;
  logic        mmio_en, mmio_wen;
  logic [31:0] mmio_addr, mmio_wdata, mmio_rdata = '0;
  logic        dmem_req, dmem_wen;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic        dmem_gnt = 1'b0, dmem_recv = 1'b0, dmem_error = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 g_clk = ~g_clk;

  frv_lsu_split dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .lsu_valid(lsu_valid), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_load(lsu_load), .lsu_store(lsu_store),
    .lsu_byte(lsu_byte), .lsu_half(lsu_half), .lsu_word(lsu_word),
    .lsu_signed(lsu_signed), .pipe_prog(pipe_prog), .hold_lsu_req(hold_lsu_req),
    .lsu_ready(lsu_ready), .lsu_a_error(lsu_a_error), .lsu_mmio(lsu_mmio),
    .lsu_rdata(lsu_rdata), .lsu_bus_error(lsu_bus_error),
    .lsu_store_berr(lsu_store_berr), .mmio_en(mmio_en), .mmio_wen(mmio_wen),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error)
  );

  task automatic next_cycle();
    @(posedge g_clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  // Present an instruction: op 0=byte 1=half 2=word.
  task automatic drive_op(input logic ld, input logic st, input int sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd);
    lsu_valid = 1'b1; lsu_load = ld; lsu_store = st;
    lsu_byte = (sz == 0); lsu_half = (sz == 1); lsu_word = (sz == 2);
    lsu_signed = sg; lsu_addr = a; lsu_wdata = wd;
  endtask

  task automatic idle_inputs();
    lsu_valid = 1'b0; lsu_load = 1'b0; lsu_store = 1'b0; lsu_byte = 1'b0;
    lsu_half = 1'b0; lsu_word = 1'b0; lsu_signed = 1'b0; pipe_prog = 1'b0;
    dmem_gnt = 1'b0; dmem_recv = 1'b0; dmem_error = 1'b0; dmem_rdata = '0;
    mmio_rdata = '0; lsu_addr = '0; lsu_wdata = '0;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    next_cycle(); next_cycle();
    settle();
    n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", lsu_ready); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", dmem_req); end
    n_checks++; if (mmio_en !== 1'b0) begin n_fail++; $display("FAIL rst_mmio_en: got %b want 0", mmio_en); end
    n_checks++; if (lsu_store_berr !== 1'b0) begin n_fail++; $display("FAIL rst_sberr: got %b want 0", lsu_store_berr); end
    n_checks++; if (lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", lsu_rdata); end
    next_cycle();
    g_resetn = 1'b1;
  endtask

  task automatic test_word_load();
    drive_op(1, 0, 2, 0, 32'h2000, 32'h0); dmem_gnt = 1'b1;
    settle();
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL wl_req: got %b want 1", dmem_req); end
    n_checks++; if (dmem_addr !== 32'h2000) begin n_fail++; $display("FAIL wl_addr: got %h want 2000", dmem_addr); end
    n_checks++; if (dmem_strb !== 4'hF || dmem_wen !== 1'b0) begin n_fail++; $display("FAIL wl_strb: got %h/%b want f/0", dmem_strb, dmem_wen); end
    n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL wl_ready_c1: got %b want 0", lsu_ready); end
    for (int c = 2; c <= 3; c++) begin
      next_cycle(); dmem_gnt = 1'b0; settle();
      n_checks++; if (lsu_ready !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL wl_wait_c%0d: ready=%b req=%b want 0/0", c, lsu_ready, dmem_req); end
    end
    next_cycle(); dmem_recv = 1'b1; dmem_rdata = 32'hCAFEBABE; pipe_prog = 1'b1;
    settle();
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL wl_ready_c4: got %b want 1", lsu_ready); end
    n_checks++; if (lsu_rdata !== 32'hCAFEBABE) begin n_fail++; $display("FAIL wl_rdata: got %h want cafebabe", lsu_rdata); end
    n_checks++; if (lsu_bus_error !== 1'b0) begin n_fail++; $display("FAIL wl_berr: got %b want 0", lsu_bus_error); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_format();
    // Signed byte at offset 3.
    drive_op(1, 0, 0, 1, 32'h2003, 32'h0); dmem_gnt = 1'b1;
    settle();
    n_checks++; if (dmem_strb !== 4'b1000) begin n_fail++; $display("FAIL sb_strb: got %b want 1000", dmem_strb); end
    next_cycle(); dmem_gnt = 1'b0; dmem_recv = 1'b1; dmem_rdata = 32'h80112233; pipe_prog = 1'b1;
    settle();
    n_checks++; if (lsu_ready !== 1'b1 || lsu_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL sb_rdata: got %b/%h want 1/ffffff80", lsu_ready, lsu_rdata); end
    next_cycle(); idle_inputs();
    // Unsigned half at offset 2, completed without pipeline advance.
    drive_op(1, 0, 1, 0, 32'h2002, 32'h0); dmem_gnt = 1'b1;
    settle();
    n_checks++; if (dmem_strb !== 4'b1100) begin n_fail++; $display("FAIL uh_strb: got %b want 1100", dmem_strb); end
    next_cycle(); dmem_gnt = 1'b0; dmem_recv = 1'b1; dmem_rdata = 32'h80112233;
    settle();
    n_checks++; if (lsu_ready !== 1'b1 || lsu_rdata !== 32'h00008011) begin n_fail++; $display("FAIL uh_rdata: got %b/%h want 1/00008011", lsu_ready, lsu_rdata); end
    next_cycle(); dmem_recv = 1'b0; dmem_rdata = 32'h0; pipe_prog = 1'b1;
    settle();
    n_checks++; if (lsu_ready !== 1'b1 || lsu_rdata !== 32'h00008011) begin n_fail++; $display("FAIL uh_held: got %b/%h want 1/00008011", lsu_ready, lsu_rdata); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_back_to_back();
    pipe_prog = 1'b1; dmem_gnt = 1'b1;
    drive_op(0, 1, 0, 0, 32'h2001, 32'h000000AB);
    settle();
    n_checks++; if (dmem_req !== 1'b1 || lsu_ready !== 1'b1) begin n_fail++; $display("FAIL st1_req: req=%b ready=%b want 1/1", dmem_req, lsu_ready); end
    n_checks++; if (dmem_wdata !== 32'hABABABAB || dmem_strb !== 4'b0010 || dmem_wen !== 1'b1) begin n_fail++; $display("FAIL st1_lane: got %h/%b/%b want abababab/0010/1", dmem_wdata, dmem_strb, dmem_wen); end
    next_cycle(); drive_op(0, 1, 1, 0, 32'h2006, 32'h00001234);
    settle();
    n_checks++; if (dmem_req !== 1'b1 || lsu_ready !== 1'b1) begin n_fail++; $display("FAIL st2_req: req=%b ready=%b want 1/1", dmem_req, lsu_ready); end
    n_checks++; if (dmem_wdata !== 32'h12341234 || dmem_strb !== 4'b1100 || dmem_addr !== 32'h2004) begin n_fail++; $display("FAIL st2_lane: got %h/%b/%h want 12341234/1100/2004", dmem_wdata, dmem_strb, dmem_addr); end
    next_cycle(); drive_op(0, 1, 2, 0, 32'h2008, 32'hDEADBEEF);
    settle();
    n_checks++; if (dmem_req !== 1'b0 || lsu_ready !== 1'b0) begin n_fail++; $display("FAIL st3_full: req=%b ready=%b want 0/0", dmem_req, lsu_ready); end
    next_cycle(); dmem_recv = 1'b1;
    settle();
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL st3_nobypass: req=%b want 0", dmem_req); end
    next_cycle(); dmem_recv = 1'b0;
    settle();
    n_checks++; if (dmem_req !== 1'b1 || lsu_ready !== 1'b1 || dmem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st3_issue: req=%b ready=%b wd=%h want 1/1/deadbeef", dmem_req, lsu_ready, dmem_wdata); end
    next_cycle(); idle_inputs(); dmem_recv = 1'b1;
    next_cycle();
    next_cycle(); dmem_recv = 1'b0;
    settle();
    n_checks++; if (lsu_store_berr !== 1'b0) begin n_fail++; $display("FAIL st_drain_sberr: got %b want 0", lsu_store_berr); end
    next_cycle();
  endtask

  task automatic test_store_berr();
    drive_op(0, 1, 2, 0, 32'h2010, 32'h5); dmem_gnt = 1'b1; pipe_prog = 1'b1;
    next_cycle(); drive_op(1, 0, 2, 0, 32'h2014, 32'h0); pipe_prog = 1'b0;
    settle();
    n_checks++; if (dmem_req !== 1'b1 || lsu_ready !== 1'b0) begin n_fail++; $display("FAIL sbe_ld_issue: req=%b ready=%b want 1/0", dmem_req, lsu_ready); end
    next_cycle(); dmem_gnt = 1'b0; dmem_recv = 1'b1; dmem_error = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    settle();
    n_checks++; if (lsu_ready !== 1'b0 || lsu_store_berr !== 1'b0) begin n_fail++; $display("FAIL sbe_st_pop: ready=%b sberr=%b want 0/0", lsu_ready, lsu_store_berr); end
    next_cycle(); dmem_error = 1'b0; dmem_rdata = 32'h11223344; pipe_prog = 1'b1;
    settle();
    n_checks++; if (lsu_store_berr !== 1'b1) begin n_fail++; $display("FAIL sbe_pulse: got %b want 1", lsu_store_berr); end
    n_checks++; if (lsu_ready !== 1'b1 || lsu_rdata !== 32'h11223344 || lsu_bus_error !== 1'b0) begin n_fail++; $display("FAIL sbe_ld_done: %b/%h/%b want 1/11223344/0", lsu_ready, lsu_rdata, lsu_bus_error); end
    next_cycle(); idle_inputs();
    settle();
    n_checks++; if (lsu_store_berr !== 1'b0) begin n_fail++; $display("FAIL sbe_one_cycle: got %b want 0", lsu_store_berr); end
    next_cycle();
  endtask

  task automatic test_kill();
    drive_op(1, 0, 2, 0, 32'h2020, 32'h0); dmem_gnt = 1'b1;
    next_cycle(); dmem_gnt = 1'b0; pipe_prog = 1'b1;
    settle();
    n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL kill_ready: got %b want 0", lsu_ready); end
    next_cycle(); idle_inputs(); dmem_recv = 1'b1; dmem_error = 1'b1; dmem_rdata = 32'h12345678;
    settle();
    n_checks++; if (lsu_ready !== 1'b0 || lsu_bus_error !== 1'b0) begin n_fail++; $display("FAIL kill_drop: ready=%b berr=%b want 0/0", lsu_ready, lsu_bus_error); end
    next_cycle(); idle_inputs();
    settle();
    n_checks++; if (lsu_store_berr !== 1'b0 || lsu_ready !== 1'b0) begin n_fail++; $display("FAIL kill_sberr: sberr=%b ready=%b want 0/0", lsu_store_berr, lsu_ready); end
    next_cycle();
  endtask

  task automatic test_mmio_and_misalign();
    drive_op(0, 1, 2, 0, 32'h2030, 32'h9); dmem_gnt = 1'b1; pipe_prog = 1'b1;
    next_cycle(); dmem_gnt = 1'b0; pipe_prog = 1'b0;
    drive_op(1, 0, 2, 0, 32'h1004, 32'h0); mmio_rdata = 32'h55AA55AA;
    settle();
    n_checks++; if (lsu_mmio !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL mm_decode: mmio=%b req=%b want 1/0", lsu_mmio, dmem_req); end
    n_checks++; if (mmio_en !== 1'b0 || lsu_ready !== 1'b0) begin n_fail++; $display("FAIL mm_wait1: en=%b ready=%b want 0/0", mmio_en, lsu_ready); end
    next_cycle(); dmem_recv = 1'b1;
    settle();
    n_checks++; if (mmio_en !== 1'b0) begin n_fail++; $display("FAIL mm_wait2: en=%b want 0", mmio_en); end
    next_cycle(); dmem_recv = 1'b0; pipe_prog = 1'b1;
    settle();
    n_checks++; if (mmio_en !== 1'b1 || mmio_wen !== 1'b0 || lsu_ready !== 1'b1) begin n_fail++; $display("FAIL mm_go: en=%b wen=%b ready=%b want 1/0/1", mmio_en, mmio_wen, lsu_ready); end
    n_checks++; if (lsu_rdata !== 32'h55AA55AA || mmio_addr !== 32'h1004) begin n_fail++; $display("FAIL mm_data: rdata=%h addr=%h want 55aa55aa/1004", lsu_rdata, mmio_addr); end
    next_cycle(); idle_inputs();
    drive_op(1, 0, 1, 0, 32'h2001, 32'h0); dmem_gnt = 1'b1; pipe_prog = 1'b1;
    settle();
    n_checks++; if (lsu_a_error !== 1'b1 || lsu_ready !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL misalign: aerr=%b ready=%b req=%b want 1/1/0", lsu_a_error, lsu_ready, dmem_req); end
    next_cycle(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_format();
    test_back_to_back();
    test_store_berr();
    test_kill();
    test_mmio_and_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
